// File: rtl/tone_arbiter.sv
// tone_arbiter: fixed-priority speaker arbiter for N_REQ tone requesters.
// Square-wave tone per grant, minimum hold, post-release gap, PDM quieting.
module tone_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DIV_W      = 17,
    parameter int unsigned MIN_HOLD   = 10000000,
    parameter int unsigned GAP_CYCLES = 1000000
) (
    input  logic                   CLK100MHZ,
    input  logic                   ck_rstn,
    input  logic                   enable,
    input  logic                   quiet,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DIV_W-1:0] div_flat,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic                   speaker,
    output logic                   pdm_out
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned HW = $clog2(MIN_HOLD + 2);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 2);
    localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [DIV_W-1:0] tone_q, tone_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             spk_q, spk_d;
    logic [6:0]       atten_q;

    logic [IW-1:0]    hi_idx;
    logic [IW-1:0]    g_idx;
    logic             req_any;
    logic [DIV_W-1:0] hi_div;
    logic [DIV_W-1:0] g_div;
    logic             hold_ok;
    logic             gap_last;
    logic             preempt;
    logic             release_ok;

    // Highest pending request and index of the current owner
    always_comb begin
        hi_idx  = '0;
        g_idx   = '0;
        req_any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i]) begin
                hi_idx  = IW'(i);
                req_any = 1'b1;
            end
            if (grant_q[i]) begin
                g_idx = IW'(i);
            end
        end
    end

    assign hi_div     = div_flat[32'(hi_idx) * DIV_W +: DIV_W];
    assign g_div      = div_flat[32'(g_idx) * DIV_W +: DIV_W];
    assign hold_ok    = (hold_q == HW'(MIN_HOLD));
    assign gap_last   = (gap_q == GW'(GAP_LAST));
    assign preempt    = hold_ok && req_any && (hi_idx > g_idx);
    assign release_ok = hold_ok && !req[g_idx];

    // Next-state: arbitration, tone generation, hold and gap timing
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        tone_d  = tone_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        spk_d   = spk_q;
        if (!enable) begin
            state_d = S_IDLE;
            grant_d = '0;
            tone_d  = '0;
            hold_d  = '0;
            gap_d   = '0;
            spk_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_any) begin
                        state_d         = S_PLAY;
                        grant_d         = '0;
                        grant_d[hi_idx] = 1'b1;
                        tone_d          = hi_div;
                        hold_d          = '0;
                        spk_d           = 1'b0;
                    end
                end
                S_PLAY: begin
                    if (preempt) begin
                        grant_d         = '0;
                        grant_d[hi_idx] = 1'b1;
                        tone_d          = hi_div;
                        hold_d          = '0;
                        spk_d           = 1'b0;
                    end else if (release_ok) begin
                        state_d = S_GAP;
                        grant_d = '0;
                        tone_d  = '0;
                        hold_d  = '0;
                        gap_d   = '0;
                        spk_d   = 1'b0;
                    end else begin
                        if (!hold_ok) begin
                            hold_d = hold_q + HW'(1);
                        end
                        if (tone_q == '0) begin
                            spk_d  = ~spk_q;
                            tone_d = g_div;
                        end else begin
                            tone_d = tone_q - DIV_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_last) begin
                        state_d = S_IDLE;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    tone_d  = '0;
                    hold_d  = '0;
                    gap_d   = '0;
                    spk_d   = 1'b0;
                end
            endcase
        end
    end

    // State registers; attenuation counter free-runs in every state
    always_ff @(posedge CLK100MHZ or negedge ck_rstn) begin
        if (!ck_rstn) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            tone_q  <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            spk_q   <= 1'b0;
            atten_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            tone_q  <= tone_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            spk_q   <= spk_d;
            atten_q <= atten_q + 7'd1;
        end
    end

    assign grant   = grant_q;
    assign busy    = (state_q != S_IDLE);
    assign speaker = spk_q;
    assign pdm_out = spk_q & (~quiet | (atten_q == 7'd0));

endmodule
